// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU data-bus address map, arbiter state encoding and helpers
// Purpose: single place for the peripheral address windows, the status-byte
//          address and the RAM arbiter state type, imported by the bus blocks.
// Ports:   none (package).
package cpu_bus_pkg;

   // Peripheral windows on the 8-bit CPU data bus.
   localparam logic [7:0] RAM_BASE_ADDR = 8'h00;
   localparam logic [7:0] RAM_LAST_ADDR = 8'h7F;
   localparam logic [7:0] IO_BASE_ADDR  = 8'h80;
   localparam logic [7:0] IO_LAST_ADDR  = 8'h8F;

   // RAM byte 0 holds the status byte; the DMA is never allowed to overwrite it.
   localparam logic [7:0] STATUS_ADDR   = 8'h00;

   typedef enum logic {
      ST_CPU = 1'b0,
      ST_DMA = 1'b1
   } arb_state_t;

   // Written as a function so a window starting at 8'h00 does not turn the
   // lower-bound compare into a constant expression.
   function automatic logic in_window(input logic [7:0] addr,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/ram_arb_fsm.sv
// rtl/ram_arb_fsm.sv - ownership FSM with starvation and burst counters for the RAM arbiter
// Purpose: decides whether the CPU or the DMA owns the RAM port each cycle.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   dma_req  in   DMA request (held until granted)
//   cpu_acc  in   CPU is accessing the RAM window this cycle
//   sel_dma  out  1 = DMA owns the RAM port this cycle
module ram_arb_fsm
   import cpu_bus_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_BURST    = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic dma_req,
   input  logic cpu_acc,
   output logic sel_dma
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   arb_state_t state, state_next;
   logic [3:0] starve_cnt, starve_next;
   logic [3:0] burst_cnt, burst_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_CPU;
         starve_cnt <= 4'd0;
         burst_cnt  <= 4'd0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         burst_cnt  <= burst_next;
      end
   end

   always_comb begin
      state_next  = state;
      starve_next = starve_cnt;
      burst_next  = burst_cnt;
      case (state)
         ST_CPU: begin
            if (!dma_req) begin
               starve_next = 4'd0;
            end else if (!cpu_acc || (starve_cnt == STARVE_LIM)) begin
               state_next  = ST_DMA;
               starve_next = 4'd0;
            end else begin
               starve_next = sat_inc4(starve_cnt);
            end
         end
         ST_DMA: begin
            if (!dma_req) begin
               state_next  = ST_CPU;
               starve_next = 4'd0;
               burst_next  = 4'd0;
            end else if (cpu_acc) begin
               // Only cycles where the CPU is kept waiting count toward the burst.
               if (burst_cnt == BURST_LAST) begin
                  state_next = ST_CPU;
                  burst_next = 4'd0;
               end else begin
                  burst_next = sat_inc4(burst_cnt);
               end
            end
         end
      endcase
   end

   assign sel_dma = (state == ST_DMA);

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port data RAM arbiter between CPU load/store path and DMA
// Purpose: muxes the RAM port between CPU (default owner) and DMA, with
//          starvation-forced DMA grants and a burst limit back to the CPU.
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   cpu_addr/cpu_dout/cpu_wr_en/cpu_rd_en CPU access request
//   cpu_din, cpu_stall                    CPU read data (Z outside window), retry strobe
//   dma_req/dma_we/dma_addr/dma_wdata     DMA access request
//   dma_gnt                               DMA access performed this cycle
//   dma_rvalid/dma_rdata/dma_err          registered DMA completion
//   ram_addr/ram_dout/ram_wr_en/ram_rd_en RAM port, ram_din async read data
module ram_arbiter
   import cpu_bus_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR    = RAM_BASE_ADDR,
   parameter logic [7:0] LAST_ADDR    = RAM_LAST_ADDR,
   parameter int         STARVE_LIMIT = 4,
   parameter int         MAX_BURST    = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_dout,
   input  logic       cpu_wr_en,
   input  logic       cpu_rd_en,
   output logic [7:0] cpu_din,
   output logic       cpu_stall,
   input  logic       dma_req,
   input  logic       dma_we,
   input  logic [7:0] dma_addr,
   input  logic [7:0] dma_wdata,
   output logic       dma_gnt,
   output logic       dma_rvalid,
   output logic [7:0] dma_rdata,
   output logic       dma_err,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_dout,
   output logic       ram_wr_en,
   output logic       ram_rd_en,
   input  logic [7:0] ram_din
);

   logic cpu_win;
   logic cpu_acc;
   logic dma_bad;
   logic sel_dma;

   assign cpu_win = in_window(cpu_addr, BASE_ADDR, LAST_ADDR);
   assign cpu_acc = (cpu_wr_en | cpu_rd_en) & cpu_win;

   // Out-of-window accesses and writes to the status byte are granted but have no RAM effect.
   assign dma_bad = !in_window(dma_addr, BASE_ADDR, LAST_ADDR) ||
                    (dma_we && (dma_addr == STATUS_ADDR));

   ram_arb_fsm #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .MAX_BURST    (MAX_BURST)
   ) u_fsm (
      .clk     (clk),
      .reset_n (reset_n),
      .dma_req (dma_req),
      .cpu_acc (cpu_acc),
      .sel_dma (sel_dma)
   );

   assign dma_gnt   = sel_dma & dma_req;
   // Derived from address/strobes only, never from returned data.
   assign cpu_stall = sel_dma & cpu_acc;

   always_comb begin
      if (sel_dma) begin
         ram_addr  = dma_addr;
         ram_dout  = dma_wdata;
         ram_wr_en = dma_req & dma_we & !dma_bad;
         ram_rd_en = dma_req & !dma_we & !dma_bad;
      end else begin
         ram_addr  = cpu_addr;
         ram_dout  = cpu_dout;
         ram_wr_en = cpu_wr_en & cpu_win;
         ram_rd_en = cpu_rd_en & cpu_win;
      end
   end

   // Other peripherals share the CPU read bus, so release it outside the window.
   assign cpu_din = cpu_win ? ram_din : 8'hzz;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dma_rvalid <= 1'b0;
         dma_rdata  <= 8'h00;
         dma_err    <= 1'b0;
      end else begin
         dma_rvalid <= dma_gnt & !dma_we;
         dma_err    <= dma_gnt & dma_bad;
         if (dma_gnt && !dma_we) begin
            dma_rdata <= dma_bad ? 8'h00 : ram_din;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
   logic       clk;
   logic       reset_n;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_dout;
   logic       cpu_wr_en;
   logic       cpu_rd_en;
   logic [7:0] cpu_din;
   logic       cpu_stall;
   logic       dma_req;
   logic       dma_we;
   logic [7:0] dma_addr;
   logic [7:0] dma_wdata;
   logic       dma_gnt;
   logic       dma_rvalid;
   logic [7:0] dma_rdata;
   logic       dma_err;
   logic [7:0] ram_addr;
   logic [7:0] ram_dout;
   logic       ram_wr_en;
   logic       ram_rd_en;
   logic [7:0] ram_din;

   int tests;
   int fails;
   int wr_count;
   logic [7:0] mem [0:255];

   ram_arbiter #(
      .BASE_ADDR    (8'h00),
      .LAST_ADDR    (8'h7F),
      .STARVE_LIMIT (4),
      .MAX_BURST    (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_addr   (cpu_addr),
      .cpu_dout   (cpu_dout),
      .cpu_wr_en  (cpu_wr_en),
      .cpu_rd_en  (cpu_rd_en),
      .cpu_din    (cpu_din),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .dma_err    (dma_err),
      .ram_addr   (ram_addr),
      .ram_dout   (ram_dout),
      .ram_wr_en  (ram_wr_en),
      .ram_rd_en  (ram_rd_en),
      .ram_din    (ram_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: async read, sync write.
   assign ram_din = mem[ram_addr];
   always @(posedge clk) begin
      if (ram_wr_en) begin
         mem[ram_addr] <= ram_dout;
         wr_count = wr_count + 1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_idle;
      cpu_wr_en = 1'b0;
      cpu_rd_en = 1'b0;
      cpu_addr  = 8'h00;
      cpu_dout  = 8'h00;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      cpu_idle();
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
      #12;
      tests++;
      if (dma_rvalid !== 1'b0 || dma_err !== 1'b0 || dma_rdata !== 8'h00) begin
         fails++;
         $display("FAIL reset_regs: rvalid=%b err=%b rdata=%h, required 0 0 00", dma_rvalid, dma_err, dma_rdata);
      end
      tests++;
      if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin
         fails++;
         $display("FAIL reset_comb: gnt=%b stall=%b wr=%b rd=%b, required 0 0 0 0", dma_gnt, cpu_stall, ram_wr_en, ram_rd_en);
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_cpu_only;
      int w0;
      mem[8'h10] = 8'h00;
      w0 = wr_count;
      cpu_addr = 8'h10; cpu_dout = 8'hA5; cpu_wr_en = 1'b1;
      #2;
      tests++;
      if (ram_wr_en !== 1'b1 || ram_addr !== 8'h10 || ram_dout !== 8'hA5 || cpu_stall !== 1'b0) begin
         fails++;
         $display("FAIL cpu_write: wr=%b addr=%h dout=%h stall=%b, required 1 10 a5 0", ram_wr_en, ram_addr, ram_dout, cpu_stall);
      end
      tick();
      cpu_wr_en = 1'b0; cpu_rd_en = 1'b1;
      #2;
      tests++;
      if (cpu_din !== 8'hA5 || ram_rd_en !== 1'b1 || ram_wr_en !== 1'b0 || cpu_stall !== 1'b0) begin
         fails++;
         $display("FAIL cpu_read: din=%h rd=%b wr=%b stall=%b, required a5 1 0 0", cpu_din, ram_rd_en, ram_wr_en, cpu_stall);
      end
      tick();
      cpu_idle();
      tests++;
      if (wr_count - w0 !== 1) begin
         fails++;
         $display("FAIL cpu_write_count: %0d writes, required 1", wr_count - w0);
      end
      tick();
   endtask

   task automatic test_dma_read;
      mem[8'h20] = 8'h3C;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20;
      #2;
      tests++;
      if (dma_gnt !== 1'b0) begin
         fails++;
         $display("FAIL dma_gnt_c0: gnt=%b, required 0", dma_gnt);
      end
      tick();
      #2;
      tests++;
      if (dma_gnt !== 1'b1 || ram_rd_en !== 1'b1 || ram_addr !== 8'h20) begin
         fails++;
         $display("FAIL dma_gnt_c1: gnt=%b rd=%b addr=%h, required 1 1 20", dma_gnt, ram_rd_en, ram_addr);
      end
      tick();
      dma_req = 1'b0;
      tests++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 8'h3C || dma_err !== 1'b0) begin
         fails++;
         $display("FAIL dma_rdata_c2: rvalid=%b rdata=%h err=%b, required 1 3c 0", dma_rvalid, dma_rdata, dma_err);
      end
      tick();
      tests++;
      if (dma_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL dma_rvalid_pulse: rvalid=%b, required 0", dma_rvalid);
      end
      tick();
   endtask

   task automatic test_contention;
      mem[8'h30] = 8'h11;
      mem[8'h40] = 8'h00;
      cpu_addr = 8'h30; cpu_rd_en = 1'b1;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 8'h77;
      for (int k = 0; k < 5; k++) begin
         #2;
         tests++;
         if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            fails++;
            $display("FAIL starve_wait_%0d: gnt=%b stall=%b, required 0 0", k, dma_gnt, cpu_stall);
         end
         tick();
      end
      // CPU attempts a write in the forced-grant cycle; it must not reach the RAM.
      cpu_rd_en = 1'b0; cpu_wr_en = 1'b1; cpu_dout = 8'h99;
      #2;
      tests++;
      if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1 || ram_addr !== 8'h40 || ram_dout !== 8'h77) begin
         fails++;
         $display("FAIL starve_grant: gnt=%b stall=%b addr=%h dout=%h, required 1 1 40 77", dma_gnt, cpu_stall, ram_addr, ram_dout);
      end
      tick();
      dma_req = 1'b0;
      cpu_idle();
      tests++;
      if (mem[8'h30] !== 8'h11 || mem[8'h40] !== 8'h77) begin
         fails++;
         $display("FAIL starve_mem: mem30=%h mem40=%h, required 11 77", mem[8'h30], mem[8'h40]);
      end
      tick();
      tick();
   endtask

   task automatic test_burst;
      int idx;
      int run;
      int max_run;
      logic exp_gnt;
      for (int i = 0; i < 8; i++) mem[8'h50 + i] = 8'h00;
      idx = 0; run = 0; max_run = 0;
      cpu_addr = 8'h30; cpu_rd_en = 1'b1;
      dma_we = 1'b1;
      // Expected pattern with limits 4/4: 5 CPU cycles, 4 DMA grants, repeated.
      for (int c = 0; c < 18; c++) begin
         dma_req   = (idx < 8);
         dma_addr  = 8'h50 + 8'(idx);
         dma_wdata = 8'hC0 + 8'(idx);
         #2;
         exp_gnt = ((c % 9) >= 5);
         tests++;
         if (dma_gnt !== exp_gnt) begin
            fails++;
            $display("FAIL burst_gnt_c%0d: gnt=%b, required %b", c, dma_gnt, exp_gnt);
         end
         if (cpu_stall === 1'b1) run++;
         else run = 0;
         if (run > max_run) max_run = run;
         if (dma_gnt === 1'b1) idx++;
         tick();
      end
      dma_req = 1'b0;
      cpu_idle();
      tests++;
      if (max_run > 4 || idx !== 8) begin
         fails++;
         $display("FAIL burst_stall: max stall run %0d grants %0d, required <=4 and 8", max_run, idx);
      end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (mem[8'h50 + i] !== 8'hC0 + 8'(i)) begin
            fails++;
            $display("FAIL burst_mem_%0d: %h, required %h", i, mem[8'h50 + i], 8'hC0 + 8'(i));
         end
      end
      tick();
      tick();
   endtask

   task automatic test_bad;
      int w0;
      mem[8'h00] = 8'h5A;
      w0 = wr_count;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h00; dma_wdata = 8'hFF;
      tick();
      #2;
      tests++;
      if (dma_gnt !== 1'b1 || ram_wr_en !== 1'b0) begin
         fails++;
         $display("FAIL bad_wr_gnt: gnt=%b wr=%b, required 1 0", dma_gnt, ram_wr_en);
      end
      tick();
      dma_we = 1'b0; dma_addr = 8'h90;
      tests++;
      if (dma_err !== 1'b1 || dma_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL bad_wr_err: err=%b rvalid=%b, required 1 0", dma_err, dma_rvalid);
      end
      #1;
      tests++;
      if (dma_gnt !== 1'b1 || ram_wr_en !== 1'b0) begin
         fails++;
         $display("FAIL bad_rd_gnt: gnt=%b wr=%b, required 1 0", dma_gnt, ram_wr_en);
      end
      tick();
      dma_req = 1'b0;
      tests++;
      if (dma_err !== 1'b1 || dma_rvalid !== 1'b1 || dma_rdata !== 8'h00) begin
         fails++;
         $display("FAIL bad_rd_done: err=%b rvalid=%b rdata=%h, required 1 1 00", dma_err, dma_rvalid, dma_rdata);
      end
      tick();
      tests++;
      if (dma_err !== 1'b0 || mem[8'h00] !== 8'h5A || wr_count !== w0) begin
         fails++;
         $display("FAIL bad_side_effect: err=%b status=%h writes=%0d, required 0 5a 0", dma_err, mem[8'h00], wr_count - w0);
      end
      tick();
   endtask

   task automatic test_reset_mid_burst;
      int w0;
      mem[8'h60] = 8'h00;
      mem[8'h61] = 8'h00;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h60; dma_wdata = 8'hD0;
      tick();
      tick();
      dma_addr = 8'h61; dma_wdata = 8'hD1;
      #2;
      reset_n = 1'b0;
      w0 = wr_count;
      #1;
      tests++;
      if (dma_gnt !== 1'b0 || ram_wr_en !== 1'b0 || dma_rvalid !== 1'b0 || dma_err !== 1'b0 || dma_rdata !== 8'h00) begin
         fails++;
         $display("FAIL rst_mid_outputs: gnt=%b wr=%b rvalid=%b err=%b rdata=%h, required 0 0 0 0 00",
                  dma_gnt, ram_wr_en, dma_rvalid, dma_err, dma_rdata);
      end
      tick();
      tests++;
      if (mem[8'h60] !== 8'hD0 || mem[8'h61] !== 8'h00 || wr_count !== w0) begin
         fails++;
         $display("FAIL rst_mid_mem: mem60=%h mem61=%h writes=%0d, required d0 00 0", mem[8'h60], mem[8'h61], wr_count - w0);
      end
      reset_n = 1'b1;
      #2;
      tests++;
      if (dma_gnt !== 1'b0) begin
         fails++;
         $display("FAIL rst_release_state: gnt=%b, required 0", dma_gnt);
      end
      tick();
      #1;
      tests++;
      if (dma_gnt !== 1'b1) begin
         fails++;
         $display("FAIL rst_regrant: gnt=%b, required 1", dma_gnt);
      end
      tick();
      dma_req = 1'b0;
      tick();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      wr_count = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_cpu_only();
      test_dma_read();
      test_contention();
      test_burst();
      test_bad();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
